// File: rtl/conv_enc_packer.sv
// -----------------------------------------------------------------------------
// conv_enc_packer
//
// Rate-1/2, constraint-length-3 convolutional encoder that feeds the Viterbi
// receive path. Information bytes arrive over a valid/ready handshake and are
// encoded MSB first, one bit per clock. The eight 2-bit symbols of a byte are
// packed into one 16-bit word, which is offered to the downstream FIFO with a
// single-cycle write strobe. Downstream back-pressure (FIFO full) holds the
// word in SEND until it can be written.
//
// Ports
//   clk           in   1   rising-edge clock
//   rst_n         in   1   asynchronous active-low reset
//   byte_i        in   8   information byte, sampled on handshake
//   byte_valid_i  in   1   byte_i is valid
//   byte_ready_o  out  1   block can accept a byte (IDLE)
//   clear_i       in   1   synchronous encoder-state clear, IDLE only
//   busy_i        in   1   downstream FIFO full
//   data_o        out  16  packed symbol word (first bit's pair in [15:14])
//   dvalid_o      out  1   one-cycle write strobe for data_o
//
// Parameters
//   G0  generator for symbol bit 1; bit 2 taps u, bit 1 taps s1, bit 0 taps s2
//   G1  generator for symbol bit 0; same tap mapping
// -----------------------------------------------------------------------------
module conv_enc_packer #(
    parameter logic [2:0] G0 = 3'b111,
    parameter logic [2:0] G1 = 3'b101
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  byte_i,
    input  logic        byte_valid_i,
    output logic        byte_ready_o,
    input  logic        clear_i,
    input  logic        busy_i,
    output logic [15:0] data_o,
    output logic        dvalid_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ENCODE = 2'd1,
        ST_SEND   = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_s1;      // previous info bit
    logic        r_s2;      // info bit before r_s1
    logic [7:0]  r_shift;   // byte being encoded, MSB is the next bit
    logic [2:0]  r_cnt;     // index of the bit currently being encoded
    logic [15:0] r_data;    // packed symbol word
    logic        r_ready;

    logic        w_u;
    logic [2:0]  w_taps;
    logic [1:0]  w_sym;
    logic        w_write;

    assign w_u    = r_shift[7];
    assign w_taps = {w_u, r_s1, r_s2};
    assign w_sym  = {^(G0 & w_taps), ^(G1 & w_taps)};

    // The strobe is a Mealy term so a release of busy_i is seen in the same
    // cycle; the word itself comes straight from a register.
    assign w_write = (r_state == ST_SEND) && !busy_i;

    assign dvalid_o     = w_write;
    assign data_o       = r_data;
    assign byte_ready_o = r_ready;

    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values of the others (s2 <= s1 needs the old s1).
    // NOTE: every register, including the word and shift register, is reset so
    // a reset mid-byte discards the partial word rather than replaying it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_shift <= 8'h00;
            r_cnt   <= 3'd0;
            r_data  <= 16'h0000;
            r_ready <= 1'b1;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    // A clear in the same cycle as a handshake takes effect
                    // before the first bit is encoded.
                    if (clear_i) begin
                        r_s1 <= 1'b0;
                        r_s2 <= 1'b0;
                    end
                    if (byte_valid_i) begin
                        r_shift <= byte_i;
                        r_cnt   <= 3'd0;
                        r_ready <= 1'b0;
                        r_state <= ST_ENCODE;
                    end
                end

                ST_ENCODE: begin
                    r_s1    <= w_u;
                    r_s2    <= r_s1;
                    r_shift <= {r_shift[6:0], 1'b0};
                    r_data  <= {r_data[13:0], w_sym};
                    if (r_cnt == 3'd7) begin
                        // Counter parks at 7 rather than wrapping.
                        r_state <= ST_SEND;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end

                ST_SEND: begin
                    if (w_write) begin
                        r_ready <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end

                default: begin
                    r_ready <= 1'b1;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_enc_packer.sv
// -----------------------------------------------------------------------------
// tb_conv_enc_packer
//
// Directed bench for conv_enc_packer. The stimulus process pushes the expected
// word and the cycle its strobe must appear in onto a scoreboard queue at each
// handshake; an independent monitor pops and compares whenever dvalid_o is
// high. Cycle numbers are posedge counts; a word handed over on edge H is
// expected in the period following edge H+8 (H+14 with the stall used below).
// -----------------------------------------------------------------------------
module tb_conv_enc_packer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  byte_i = 8'h00;
    logic        byte_valid_i = 1'b0;
    logic        clear_i = 1'b0;
    logic        busy_i = 1'b0;
    logic        byte_ready_o;
    logic [15:0] data_o;
    logic        dvalid_o;

    conv_enc_packer #(
        .G0(3'b111),
        .G1(3'b101)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .byte_i       (byte_i),
        .byte_valid_i (byte_valid_i),
        .byte_ready_o (byte_ready_o),
        .clear_i      (clear_i),
        .busy_i       (busy_i),
        .data_o       (data_o),
        .dvalid_o     (dvalid_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [15:0] data;
        int          cyc;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (dvalid_o === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_strobe: got word %h at cycle %0d, required no strobe", data_o, cyc);
            end else begin
                mon_e = sb_q.pop_front();
                check("word_data", data_o, mon_e.data);
                check("word_cycle", cyc, mon_e.cyc);
            end
        end
    end

    // Advance to just after the next rising edge; all stimulus changes here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    // Offer a byte; h returns the posedge count after the handshake edge.
    task automatic offer(input logic [7:0] b, input logic clr, input logic hold,
                         input logic push, input logic [15:0] exp, input int lat,
                         output int h);
        int guard;
        guard        = 0;
        byte_i       = b;
        byte_valid_i = 1'b1;
        clear_i      = clr;
        while (byte_ready_o !== 1'b1 && guard < 50) begin
            tick();
            guard++;
        end
        if (guard >= 50) begin
            n_tests++;
            n_fail++;
            $display("FAIL handshake_timeout: byte_ready_o %b, required 1", byte_ready_o);
        end
        h = cyc + 1;
        if (push) sb_q.push_back('{data: exp, cyc: h + lat});
        tick();
        clear_i = 1'b0;
        if (!hold) byte_valid_i = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (sb_q.size() != 0 && g < 100) begin
            tick();
            g++;
        end
        check("drain_pending", sb_q.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int h, h1, h2, h3;

        // Reset values while rst_n is held low.
        #12;
        check("reset_data", data_o, 16'h0000);
        check("reset_ready", byte_ready_o, 1'b1);
        check("reset_dvalid", dvalid_o, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();

        // Single byte from zero state, 9-cycle latency.
        offer(8'h80, 1'b0, 1'b0, 1'b1, 16'hEC00, 8, h);
        drain();

        // Continuous stream, then the same with a clear on the 0x00 handshake.
        offer(8'hFF, 1'b0, 1'b0, 1'b1, 16'hDAAA, 8, h);
        drain();
        offer(8'h00, 1'b0, 1'b0, 1'b1, 16'h7000, 8, h);
        drain();
        offer(8'hFF, 1'b0, 1'b0, 1'b1, 16'hDAAA, 8, h);
        drain();
        offer(8'h00, 1'b1, 1'b0, 1'b1, 16'h0000, 8, h);
        drain();

        // Back-pressure from cycle 8 through cycle 14, released at cycle 15.
        offer(8'h80, 1'b0, 1'b0, 1'b1, 16'hEC00, 14, h);
        wait_until(h + 7);
        busy_i = 1'b1;
        for (int c = h + 8; c <= h + 13; c++) begin
            wait_until(c);
            @(negedge clk);
            check("stall_dvalid", dvalid_o, 1'b0);
            check("stall_data", data_o, 16'hEC00);
            check("stall_ready", byte_ready_o, 1'b0);
        end
        wait_until(h + 14);
        busy_i = 1'b0;
        drain();

        // Back-to-back bytes with byte_valid_i held high.
        offer(8'h80, 1'b0, 1'b1, 1'b1, 16'hEC00, 8, h1);
        offer(8'h00, 1'b0, 1'b1, 1'b1, 16'h0000, 8, h2);
        offer(8'hFF, 1'b0, 1'b0, 1'b1, 16'hDAAA, 8, h3);
        check("b2b_gap_1", h2 - h1, 10);
        check("b2b_gap_2", h3 - h2, 10);
        drain();

        // Asynchronous reset during ENCODE cycle 4; the partial word is lost.
        offer(8'h55, 1'b0, 1'b0, 1'b0, 16'h0000, 8, h);
        wait_until(h + 3);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_data", data_o, 16'h0000);
        check("midrst_ready", byte_ready_o, 1'b1);
        check("midrst_dvalid", dvalid_o, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        repeat (15) tick();
        check("postrst_ready", byte_ready_o, 1'b1);
        offer(8'h80, 1'b0, 1'b0, 1'b1, 16'hEC00, 8, h);
        drain();

        // clear_i pulses in ENCODE and SEND are ignored.
        offer(8'hFF, 1'b0, 1'b0, 1'b1, 16'hDAAA, 8, h);
        wait_until(h + 4);
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        wait_until(h + 8);
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        drain();
        offer(8'h00, 1'b0, 1'b0, 1'b1, 16'h7000, 8, h);
        drain();

        repeat (5) tick();
        check("scoreboard_empty", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
